// File: rtl/uart_pkg.sv
// Shared types and constants for the UART auto-baud controller.
// Holds the FSM encoding, the 0x55 sync-character geometry and the debug view.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        MEAS  = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    // 0x55 framed 8N1 has five falling edges; edge 1 to edge 5 spans 2^3 bits.
    localparam int SYNC_EDGES     = 5;
    localparam int SYNC_SPAN_LOG2 = 3;

    typedef struct packed {
        state_e     state;
        logic       rx_s;
        logic [2:0] edges;
    } dbg_t;

endpackage

// File: rtl/uart_rx_sync.sv
// RX front end: two-flop synchronizer followed by a registered falling-edge detect.
// Every edge sees the same latency, so it cancels out of a span measurement.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic fall_q;

    // Line idles high, so every stage resets to 1 and no edge is seen out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fall_q <= prev_q & ~sync_q;
        end
    end

    assign rx_s = sync_q;
    assign fall = fall_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times a 0x55 sync character on rx and loads the rounded
// division into the baud generator, restarting it; the last good division survives errors.
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned      CNT_W       = 24,
    parameter int unsigned      OVS_LOG2    = 0,
    parameter logic [31:0]      DEFAULT_DIV = 32'd867,
    parameter logic [31:0]      MIN_DIV     = 32'd1,
    parameter logic [CNT_W-1:0] MAX_COUNT   = {CNT_W{1'b1}}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        arm,
    output logic [31:0] baud_division,
    output logic        baud_rst,
    output logic        div_valid,
    output logic        err,
    output logic        busy,
    output logic        locked,
    output dbg_t        dbg_o
);

    localparam int              SHIFT     = SYNC_SPAN_LOG2 + int'(OVS_LOG2);
    localparam logic [CNT_W:0]  ROUND     = (CNT_W+1)'(1) << (SHIFT - 1);
    localparam logic [2:0]      LAST_EDGE = 3'(SYNC_EDGES - 2);

    logic rx_s;
    logic fall;

    uart_rx_sync u_rx_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] span_q, span_d;
    logic [2:0]       edges_q, edges_d;
    logic [31:0]      div_q, div_d;
    logic             busy_q, locked_q, dv_q, brst_q, err_q;

    // Rounded division; one extra bit so span + ROUND never wraps.
    logic [CNT_W:0] quo;
    logic [31:0]    quo_m1;
    logic           calc_ok;

    assign quo     = ({1'b0, span_q} + ROUND) >> SHIFT;
    assign quo_m1  = 32'(quo) - 32'd1;
    assign calc_ok = (quo != '0) && (quo_m1 >= MIN_DIV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        span_d  = span_q;
        edges_d = edges_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                if (arm) state_d = ARMED;
            end
            ARMED: begin
                if (fall) begin
                    state_d = MEAS;
                    cnt_d   = '0;
                    edges_d = '0;
                end
            end
            MEAS: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout wins over a coincident edge.
                if (cnt_d == MAX_COUNT) begin
                    state_d = ERR;
                end else if (fall) begin
                    if (edges_q == LAST_EDGE) begin
                        span_d  = cnt_d;
                        state_d = CALC;
                    end else begin
                        edges_d = edges_q + 1'b1;
                    end
                end
            end
            CALC: begin
                if (calc_ok) begin
                    div_d   = quo_m1;
                    state_d = DONE;
                end else begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            span_q   <= '0;
            edges_q  <= '0;
            div_q    <= DEFAULT_DIV;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            dv_q     <= 1'b0;
            brst_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            span_q   <= span_d;
            edges_q  <= edges_d;
            div_q    <= div_d;
            busy_q   <= (state_d != IDLE);
            locked_q <= locked_q | (state_d == DONE);
            dv_q     <= (state_d == DONE);
            brst_q   <= (state_d == DONE);
            err_q    <= (state_d == ERR);
        end
    end

    assign baud_division = div_q;
    assign baud_rst      = brst_q;
    assign div_valid     = dv_q;
    assign err           = err_q;
    assign busy          = busy_q;
    assign locked        = locked_q;
    assign dbg_o         = '{state: state_q, rx_s: rx_s, edges: edges_q};

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: a 1x instance (short timeout) and a 16x instance
// share the rx line; each result pulse is compared against an expected queue.
module tb_uart_autobaud_ctrl;
    import uart_pkg::*;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        rx   = 1'b1;
    logic        arm0 = 1'b0;
    logic        arm4 = 1'b0;

    logic [31:0] div0, div4;
    logic        br0, br4, dv0, dv4, err0, err4, busy0, busy4, lk0, lk4;
    dbg_t        dbg0, dbg4;

    uart_autobaud_ctrl #(
        .CNT_W(24), .OVS_LOG2(0), .DEFAULT_DIV(32'd867), .MIN_DIV(32'd1), .MAX_COUNT(24'd1000)
    ) u_dut0 (
        .clk(clk), .rst(rst), .rx(rx), .arm(arm0),
        .baud_division(div0), .baud_rst(br0), .div_valid(dv0), .err(err0),
        .busy(busy0), .locked(lk0), .dbg_o(dbg0)
    );

    uart_autobaud_ctrl #(
        .CNT_W(24), .OVS_LOG2(4), .DEFAULT_DIV(32'd867), .MIN_DIV(32'd1)
    ) u_dut4 (
        .clk(clk), .rst(rst), .rx(rx), .arm(arm4),
        .baud_division(div4), .baud_rst(br4), .div_valid(dv4), .err(err4),
        .busy(busy4), .locked(lk4), .dbg_o(dbg4)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [35:0] exp_q0[$];
    logic [35:0] exp_q4[$];
    int          t_meas0 = -1;
    int          t_err0 = -1;
    logic        busy_after_err = 1'b1;
    state_e      prev_st0 = IDLE;

    typedef struct {
        int          cpb;
        logic [31:0] div0;
        logic        lk0;
        logic        e0;
        logic [31:0] div4;
        logic        lk4;
        logic        e4;
    } vec_t;

    vec_t tbl[8];

    // Event record: {err, div_valid, baud_rst, baud_division, locked}
    function automatic logic [35:0] mk(input logic e, input logic [31:0] d, input logic lk);
        return {e, ~e, ~e, d, lk};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (dv0 || err0 || br0) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_event: got err=%0b dv=%0b div=%0d expected no event",
                         err0, dv0, div0);
            end else begin
                check("dut0_event", 64'({err0, dv0, br0, div0, lk0}), 64'(exp_q0.pop_front()));
            end
        end
        if (dv4 || err4 || br4) begin
            if (exp_q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4_unexpected_event: got err=%0b dv=%0b div=%0d expected no event",
                         err4, dv4, div4);
            end else begin
                check("dut4_event", 64'({err4, dv4, br4, div4, lk4}), 64'(exp_q4.pop_front()));
            end
        end
        if (dbg0.state == MEAS && prev_st0 != MEAS && t_meas0 < 0) t_meas0 = cyc;
        if (err0 && t_err0 < 0) t_err0 = cyc;
        if (t_err0 >= 0 && cyc == t_err0 + 1) busy_after_err = busy0;
        prev_st0 = dbg0.state;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_arm(input logic a0, input logic a4);
        arm0 = a0;
        arm4 = a4;
        step();
        arm0 = 1'b0;
        arm4 = 1'b0;
    endtask

    // 0x55 framed 8N1, LSB first; optional arm0 pulse at the start of bit arm_bit.
    task automatic send_sync(input int cpb, input int arm_bit);
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            for (int c = 0; c < cpb; c++) begin
                arm0 = (i == arm_bit && c == 0);
                step();
            end
            arm0 = 1'b0;
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q4.size() != 0) && n < bound) begin
            step();
            n++;
        end
        check({name, "_dut0_pending"}, 64'(exp_q0.size()), 64'd0);
        check({name, "_dut4_pending"}, 64'(exp_q4.size()), 64'd0);
        idle(3);
        check({name, "_busy"}, {62'd0, busy0, busy4}, 64'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_div0"}, 64'(div0), 64'd867);
        check({name, "_div4"}, 64'(div4), 64'd867);
        check({name, "_flags0"}, {59'd0, br0, dv0, err0, busy0, lk0}, 64'd0);
        check({name, "_flags4"}, {59'd0, br4, dv4, err4, busy4, lk4}, 64'd0);
        check({name, "_state0"}, 64'(dbg0.state), 64'(IDLE));
        check({name, "_state4"}, 64'(dbg4.state), 64'(IDLE));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected results per row, derived by hand from span = 8*cpb.
        tbl[0] = '{8,   32'd7,   1'b1, 1'b0, 32'd867, 1'b0, 1'b1};
        tbl[1] = '{16,  32'd15,  1'b1, 1'b0, 32'd867, 1'b0, 1'b1};
        tbl[2] = '{868, 32'd15,  1'b1, 1'b1, 32'd53,  1'b1, 1'b0};
        tbl[3] = '{2,   32'd1,   1'b1, 1'b0, 32'd53,  1'b1, 1'b1};
        tbl[4] = '{1,   32'd1,   1'b1, 1'b1, 32'd53,  1'b1, 1'b1};
        tbl[5] = '{24,  32'd23,  1'b1, 1'b0, 32'd1,   1'b1, 1'b0};
        tbl[6] = '{124, 32'd123, 1'b1, 1'b0, 32'd7,   1'b1, 1'b0};
        tbl[7] = '{125, 32'd123, 1'b1, 1'b1, 32'd7,   1'b1, 1'b0};

        // Reset
        idle(4);
        check_reset_values("reset");
        rst = 1'b1;
        idle(5);
        check_reset_values("post_reset");

        // Table-driven lock/error rows
        for (int i = 0; i < 8; i++) begin
            exp_q0.push_back(mk(tbl[i].e0, tbl[i].div0, tbl[i].lk0));
            exp_q4.push_back(mk(tbl[i].e4, tbl[i].div4, tbl[i].lk4));
            pulse_arm(1'b1, 1'b1);
            idle($urandom_range(0, 7));
            send_sync(tbl[i].cpb, -1);
            drain($sformatf("row%0d", i), 100);
        end

        // Timeout: two falls then idle; err 1000 cycles after MEAS entry
        t_meas0 = -1;
        t_err0 = -1;
        busy_after_err = 1'b1;
        exp_q0.push_back(mk(1'b1, 32'd123, 1'b1));
        pulse_arm(1'b1, 1'b0);
        rx = 1'b0; idle(16);
        rx = 1'b1; idle(16);
        rx = 1'b0; idle(16);
        rx = 1'b1;
        drain("timeout", 1200);
        check("timeout_latency", 64'(t_err0 - t_meas0), 64'd1000);
        check("timeout_busy_drop", 64'(busy_after_err), 64'd0);

        // Arm while measuring is ignored; one result only
        exp_q0.push_back(mk(1'b0, 32'd15, 1'b1));
        pulse_arm(1'b1, 1'b0);
        send_sync(16, 3);
        drain("arm_busy", 100);
        check("arm_busy_div0", 64'(div0), 64'd15);

        // Falls while idle produce nothing
        for (int i = 0; i < 20; i++) begin
            rx = ~rx;
            idle($urandom_range(2, 5));
        end
        rx = 1'b1;
        idle(6);
        check("idle_falls_state", {58'd0, dbg0.state, dbg4.state}, {58'd0, IDLE, IDLE});
        check("idle_falls_div", {div0, div4}, {32'd15, 32'd7});

        // Reset in the middle of a measurement
        pulse_arm(1'b1, 1'b1);
        rx = 1'b0; idle(16);
        rx = 1'b1; idle(16);
        rx = 1'b0; idle(16);
        rx = 1'b1; idle(8);
        check("midreset_in_meas", 64'(dbg0.state), 64'(MEAS));
        #2 rst = 1'b0;
        #1 check_reset_values("midreset");
        idle(3);
        rst = 1'b1;
        idle(5);
        check_reset_values("midreset_release");
        exp_q0.push_back(mk(1'b0, 32'd15, 1'b1));
        exp_q4.push_back(mk(1'b1, 32'd867, 1'b0));
        pulse_arm(1'b1, 1'b1);
        send_sync(16, -1);
        drain("relock", 100);
        check("relock_locked", {62'd0, lk0, lk4}, {62'd0, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
